bp_resolve: RTL and testbench

Branch-prediction bookkeeping and resolution unit that sits opposite the global-history predictor in the five-stage MIPS pipeline. It produces the hashed PC the predictor consumes in Fetch, carries each prediction alongside its instruction from F to M, and in Memory compares the prediction against the real outcome. From that comparison it drives the predictor's update inputs, raises a mispredict flush with the corrected PC, and keeps saturating branch and miss statistics.

---
 rtl/bp_resolve_if.sv | 42 ++++
 rtl/bp_resolve.sv | 90 +++++++++
 tb/tb_bp_resolve.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bp_resolve_if.sv
// Bundle between the predictor/pipeline side and the branch resolution unit.
// The slave modport is the resolver; the master modport is the pipeline that drives it.
interface bp_resolve_if #(
  parameter int unsigned HASH_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic [31:0]           pcF;
  logic                  pcsrcPF;
  logic                  stallD;
  logic                  stallE;
  logic                  stallM;
  logic                  flushD;
  logic                  flushE;
  logic                  flushM;
  logic                  branchD;
  logic                  pcsrcM;
  logic [31:0]           branch_targetM;
  logic [31:0]           pc_fallthroughM;
  logic [HASH_WIDTH-1:0] hashed_pcF;
  logic                  pred_takenD;
  logic                  branchM;
  logic [HASH_WIDTH-1:0] hashed_pcM;
  logic                  pcsrcPM;
  logic                  mispredictM;
  logic [31:0]           redirect_pcM;
  logic [CNT_WIDTH-1:0]  branch_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;

  modport slave (
    input  pcF, pcsrcPF, stallD, stallE, stallM, flushD, flushE, flushM,
    input  branchD, pcsrcM, branch_targetM, pc_fallthroughM,
    output hashed_pcF, pred_takenD, branchM, hashed_pcM, pcsrcPM,
    output mispredictM, redirect_pcM, branch_cnt, miss_cnt
  );

  modport master (
    output pcF, pcsrcPF, stallD, stallE, stallM, flushD, flushE, flushM,
    output branchD, pcsrcM, branch_targetM, pc_fallthroughM,
    input  hashed_pcF, pred_takenD, branchM, hashed_pcM, pcsrcPM,
    input  mispredictM, redirect_pcM, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/bp_resolve.sv
// Carries global-history predictions from Fetch to Memory, resolves them against the
// real outcome, drives the predictor update strobe and keeps saturating statistics.
module bp_resolve #(
  parameter int unsigned HASH_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic         clk,
  input logic         rst,
  bp_resolve_if.slave bp
);

  logic [HASH_WIDTH-1:0] d_hash_q, e_hash_q, m_hash_q;
  logic                  d_pred_q, e_pred_q, m_pred_q;
  logic                  e_branch_q, m_branch_q;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, miss_cnt_q;

  logic branch_res;
  logic miss_res;

  assign bp.hashed_pcF = bp.pcF[2 +: HASH_WIDTH] ^ bp.pcF[2+HASH_WIDTH +: HASH_WIDTH];

  // Strobe only when the branch actually leaves M, so a stalled branch updates once.
  assign branch_res = m_branch_q & ~bp.stallM;
  assign miss_res   = branch_res & (m_pred_q ^ bp.pcsrcM);

  always_comb begin
    bp.pred_takenD  = d_pred_q & bp.branchD;
    bp.branchM      = branch_res;
    bp.hashed_pcM   = m_hash_q;
    bp.pcsrcPM      = m_pred_q;
    bp.mispredictM  = miss_res;
    bp.redirect_pcM = '0;
    if (miss_res) begin
      bp.redirect_pcM = bp.pcsrcM ? bp.branch_targetM : bp.pc_fallthroughM;
    end
    bp.branch_cnt   = branch_cnt_q;
    bp.miss_cnt     = miss_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_hash_q     <= '0;
      d_pred_q     <= 1'b0;
      e_hash_q     <= '0;
      e_pred_q     <= 1'b0;
      e_branch_q   <= 1'b0;
      m_hash_q     <= '0;
      m_pred_q     <= 1'b0;
      m_branch_q   <= 1'b0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (bp.flushD) begin
        d_hash_q <= '0;
        d_pred_q <= 1'b0;
      end else if (!bp.stallD) begin
        d_hash_q <= bp.hashed_pcF;
        d_pred_q <= bp.pcsrcPF;
      end

      if (bp.flushE) begin
        e_hash_q   <= '0;
        e_pred_q   <= 1'b0;
        e_branch_q <= 1'b0;
      end else if (!bp.stallE) begin
        e_hash_q   <= d_hash_q;
        e_pred_q   <= d_pred_q;
        e_branch_q <= bp.branchD;
      end

      if (bp.flushM) begin
        m_hash_q   <= '0;
        m_pred_q   <= 1'b0;
        m_branch_q <= 1'b0;
      end else if (!bp.stallM) begin
        m_hash_q   <= e_hash_q;
        m_pred_q   <= e_pred_q;
        m_branch_q <= e_branch_q;
      end

      if (branch_res && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (miss_res && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_resolve.sv
// Directed plus randomized bench for bp_resolve with a stage-level reference model.
module tb_bp_resolve;
  localparam int unsigned HW  = 3;
  localparam int unsigned CW  = 4;
  localparam int unsigned MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_resolve_if #(.HASH_WIDTH(HW), .CNT_WIDTH(CW)) bp ();

  bp_resolve #(.HASH_WIDTH(HW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  typedef struct {
    int unsigned hash;
    bit          pred;
    bit          br;
  } stg_t;

  stg_t        md, me, mm;
  int unsigned mbc, mmc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned hash_of(input logic [31:0] pc);
    return ((pc >> 2) ^ (pc >> (2 + HW))) % (1 << HW);
  endfunction

  function automatic bit model_strobe();
    return mm.br && !bp.stallM;
  endfunction

  function automatic bit model_miss();
    return model_strobe() && (mm.pred != bp.pcsrcM);
  endfunction

  task automatic clear_in();
    rst = 1'b0;
    bp.pcF = '0; bp.pcsrcPF = 1'b0; bp.branchD = 1'b0; bp.pcsrcM = 1'b0;
    bp.stallD = 1'b0; bp.stallE = 1'b0; bp.stallM = 1'b0;
    bp.flushD = 1'b0; bp.flushE = 1'b0; bp.flushM = 1'b0;
    bp.branch_targetM = '0; bp.pc_fallthroughM = '0;
  endtask

  // Compare every output against the model mid-cycle, with inputs stable.
  task automatic check_all();
    logic [31:0] exp_redir;
    @(negedge clk);
    exp_redir = 32'h0;
    if (model_miss()) exp_redir = bp.pcsrcM ? bp.branch_targetM : bp.pc_fallthroughM;
    chk("hashed_pcF", 32'(bp.hashed_pcF), hash_of(bp.pcF));
    chk("pred_takenD", 32'(bp.pred_takenD), 32'(md.pred && bp.branchD));
    chk("branchM", 32'(bp.branchM), 32'(model_strobe()));
    chk("hashed_pcM", 32'(bp.hashed_pcM), mm.hash);
    chk("pcsrcPM", 32'(bp.pcsrcPM), 32'(mm.pred));
    chk("mispredictM", 32'(bp.mispredictM), 32'(model_miss()));
    chk("redirect_pcM", bp.redirect_pcM, exp_redir);
    chk("branch_cnt", 32'(bp.branch_cnt), mbc);
    chk("miss_cnt", 32'(bp.miss_cnt), mmc);
  endtask

  task automatic tick();
    stg_t nd, ne, nm;
    bit   s, m;
    s = model_strobe();
    m = model_miss();
    nd = bp.flushD ? '{0, 0, 0} : bp.stallD ? md : '{hash_of(bp.pcF), bp.pcsrcPF, 0};
    ne = bp.flushE ? '{0, 0, 0} : bp.stallE ? me : '{md.hash, md.pred, bp.branchD};
    nm = bp.flushM ? '{0, 0, 0} : bp.stallM ? mm : me;
    @(posedge clk);
    if (rst) begin
      md = '{0, 0, 0}; me = '{0, 0, 0}; mm = '{0, 0, 0};
      mbc = 0; mmc = 0;
    end else begin
      md = nd; me = ne; mm = nm;
      mbc = (mbc + s > MAX) ? MAX : mbc + s;
      mmc = (mmc + m > MAX) ? MAX : mmc + m;
    end
    #1;
  endtask

  task automatic step();
    check_all();
    tick();
  endtask

  initial begin
    md = '{0, 0, 0}; me = '{0, 0, 0}; mm = '{0, 0, 0};
    mbc = 0; mmc = 0;
    clear_in();
    #1;

    // Reset with every input active.
    rst = 1'b1;
    bp.pcF = 32'hFFFF_FFFF; bp.pcsrcPF = 1'b1; bp.branchD = 1'b1; bp.pcsrcM = 1'b1;
    bp.stallD = 1'b1; bp.stallE = 1'b1; bp.stallM = 1'b1;
    bp.flushD = 1'b1; bp.flushE = 1'b1; bp.flushM = 1'b1;
    bp.branch_targetM = 32'hFFFF_FFFF; bp.pc_fallthroughM = 32'hFFFF_FFFF;
    tick();
    tick();
    step();
    chk("rst_branchM", 32'(bp.branchM), 32'h0);
    chk("rst_redirect", bp.redirect_pcM, 32'h0);
    chk("rst_branch_cnt", 32'(bp.branch_cnt), 32'h0);
    clear_in();

    // Correctly predicted taken branch.
    bp.pcF = 32'h0000_0040; bp.pcsrcPF = 1'b1; step();
    clear_in(); bp.branchD = 1'b1; step();
    clear_in(); step();
    bp.pcsrcM = 1'b1; check_all();
    chk("hit_branchM", 32'(bp.branchM), 32'h1);
    chk("hit_mispredict", 32'(bp.mispredictM), 32'h0);
    chk("hit_pcsrcPM", 32'(bp.pcsrcPM), 32'h1);
    tick();
    clear_in(); step();

    // Mispredicted not-taken guess; branch was taken.
    bp.pcF = 32'h0000_0124; step();
    clear_in(); bp.branchD = 1'b1; step();
    clear_in(); step();
    bp.pcsrcM = 1'b1; bp.branch_targetM = 32'h0000_0200; bp.pc_fallthroughM = 32'h0000_0128;
    check_all();
    chk("miss_mispredict", 32'(bp.mispredictM), 32'h1);
    chk("miss_redirect", bp.redirect_pcM, 32'h0000_0200);
    tick();
    clear_in(); step();

    // Branch held in M for three cycles: exactly one strobe on release.
    bp.pcF = 32'h0000_0300; bp.pcsrcPF = 1'b1; step();
    clear_in(); bp.branchD = 1'b1; step();
    clear_in(); step();
    for (int i = 0; i < 3; i++) begin
      bp.stallM = 1'b1; bp.pcsrcM = 1'b1; check_all();
      chk("stall_branchM", 32'(bp.branchM), 32'h0);
      tick();
    end
    bp.stallM = 1'b0; check_all();
    chk("release_branchM", 32'(bp.branchM), 32'h1);
    tick();
    clear_in(); step();

    // Branch in E with flushM: M cleared, no strobe.
    bp.pcF = 32'h0000_0440; bp.pcsrcPF = 1'b1; step();
    clear_in(); bp.branchD = 1'b1; step();
    clear_in(); bp.flushM = 1'b1; step();
    clear_in(); check_all();
    chk("flushM_branchM", 32'(bp.branchM), 32'h0);
    tick();

    // Flush and stall together at D: flush wins.
    bp.pcF = 32'h0000_0500; bp.pcsrcPF = 1'b1; step();
    clear_in(); bp.stallD = 1'b1; bp.flushD = 1'b1; step();
    clear_in(); bp.branchD = 1'b1; check_all();
    chk("flushD_pred_takenD", 32'(bp.pred_takenD), 32'h0);
    tick();
    clear_in();

    // Saturation: more branches than the counter can hold.
    for (int i = 0; i < 22; i++) begin
      bp.pcF = $urandom; bp.pcsrcPF = 1'($urandom); bp.branchD = 1'b1;
      bp.pcsrcM = 1'($urandom);
      step();
    end
    clear_in();
    for (int i = 0; i < 3; i++) step();
    chk("sat_branch_cnt", 32'(bp.branch_cnt), 32'hF);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bp.pcF = $urandom; bp.pcsrcPF = 1'($urandom); bp.branchD = 1'($urandom);
      bp.pcsrcM = 1'($urandom);
      bp.stallD = ($urandom_range(0, 4) == 0); bp.stallE = ($urandom_range(0, 4) == 0);
      bp.stallM = ($urandom_range(0, 4) == 0);
      bp.flushD = ($urandom_range(0, 7) == 0); bp.flushE = ($urandom_range(0, 7) == 0);
      bp.flushM = ($urandom_range(0, 7) == 0);
      bp.branch_targetM = $urandom; bp.pc_fallthroughM = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
